// File: rtl/intersection_traffic_model_pkg.sv
// Shared constants for the five-lane intersection model: lane indices,
// per-lane flow state and the legal non-red light sets.
package traffic_model_pkg;

   localparam int NUM_LANES = 5;

   localparam int LANE_ES = 0;
   localparam int LANE_WS = 1;
   localparam int LANE_EL = 2;
   localparam int LANE_WL = 3;
   localparam int LANE_NS = 4;

   typedef enum logic {
      STOPPED = 1'b0,
      FLOWING = 1'b1
   } lane_state_t;

   // Maximal sets of lanes that may be non-red together (bit = lane index).
   localparam logic [NUM_LANES-1:0] LEGAL_ES_WS = 5'b00011;
   localparam logic [NUM_LANES-1:0] LEGAL_ES_EL = 5'b00101;
   localparam logic [NUM_LANES-1:0] LEGAL_WS_WL = 5'b01010;
   localparam logic [NUM_LANES-1:0] LEGAL_WL_EL = 5'b01100;
   localparam logic [NUM_LANES-1:0] LEGAL_NS    = 5'b10000;

   // A non-red set is legal when it fits entirely inside one legal set.
   // The empty (all-red) set fits inside every one of them.
   function automatic logic light_set_legal(input logic [NUM_LANES-1:0] non_red);
      logic legal;
      legal = 1'b0;
      legal = legal | ((non_red & ~LEGAL_ES_WS) == 5'b00000);
      legal = legal | ((non_red & ~LEGAL_ES_EL) == 5'b00000);
      legal = legal | ((non_red & ~LEGAL_WS_WL) == 5'b00000);
      legal = legal | ((non_red & ~LEGAL_WL_EL) == 5'b00000);
      legal = legal | ((non_red & ~LEGAL_NS)    == 5'b00000);
      return legal;
   endfunction

endpackage

// File: rtl/light_package.sv
// Light colour encoding shared by the traffic-light controller and the
// intersection model. Encoding 2'b11 is unused and never legal.
package light_package;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } colors;

endpackage

// File: rtl/intersection_traffic_model_if.sv
// Bundle of everything exchanged between the light controller side
// (master) and the intersection model (slave).
interface intersection_traffic_model_if #(
   parameter int CNT_W = 4
);
   import light_package::*;

   logic [4:0]         arrive;
   colors              e_str_light;
   colors              w_str_light;
   colors              e_left_light;
   colors              w_left_light;
   colors              ns_light;

   logic               e_str_sensor;
   logic               w_str_sensor;
   logic               e_left_sensor;
   logic               w_left_sensor;
   logic               ns_sensor;
   logic [4:0]         depart;
   logic [5*CNT_W-1:0] queue_cnt;
   logic [4:0]         overflow;
   logic               conflict;
   logic               conflict_seen;

   modport master (
      output arrive, e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
      input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
      input  depart, queue_cnt, overflow, conflict, conflict_seen
   );

   modport slave (
      input  arrive, e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
      output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
      output depart, queue_cnt, overflow, conflict, conflict_seen
   );

endinterface

// File: rtl/intersection_traffic_model_lane_queue.sv
// One lane of the intersection: car queue counter, sticky overflow flag and
// a STOPPED/FLOWING state machine with a down-counting launch timer.
module lane_queue
   import traffic_model_pkg::*;
#(
   parameter int CNT_W      = 4,
   parameter int STARTUP    = 1,
   parameter int DEPART_GAP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arrive,
   input  logic             go,
   input  logic             amber,
   output logic             depart,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int TMR_MAX = (STARTUP > DEPART_GAP) ? STARTUP : DEPART_GAP;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] T_START = TMR_W'(STARTUP);
   localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(DEPART_GAP - 1);
   localparam logic [TMR_W-1:0] T_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
   localparam logic [CNT_W-1:0] C_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX   = {CNT_W{1'b1}};

   lane_state_t      state_r;
   logic [TMR_W-1:0] tmr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ovf_r;
   logic             active_s;
   logic             depart_s;

   // Lane moves on green, or on yellow only if cars were already flowing;
   // a car leaves when the timer has expired and the queue is not empty.
   always_comb begin
      active_s = 1'b0;
      depart_s = 1'b0;
      if (go) begin
         active_s = 1'b1;
      end else if (amber && (state_r == FLOWING)) begin
         active_s = 1'b1;
      end else begin
         active_s = 1'b0;
      end
      if (active_s && (tmr_r == T_ZERO) && (cnt_r != C_ZERO)) begin
         depart_s = 1'b1;
      end else begin
         depart_s = 1'b0;
      end
   end

   // Flow state, launch timer, queue count and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= STOPPED;
         tmr_r   <= T_START;
         cnt_r   <= C_ZERO;
         ovf_r   <= 1'b0;
      end else begin
         if (!go && !amber) begin
            state_r <= STOPPED;
            tmr_r   <= T_START;
         end else if (active_s) begin
            if (tmr_r != T_ZERO) begin
               tmr_r <= tmr_r - T_ONE;
            end else if (cnt_r != C_ZERO) begin
               tmr_r   <= T_GAP;
               state_r <= FLOWING;
            end else begin
               state_r <= FLOWING;
            end
         end else begin
            // yellow while stopped: freeze, never launch a new car
            state_r <= state_r;
            tmr_r   <= tmr_r;
         end

         case ({arrive, depart_s})
            2'b10: begin
               if (cnt_r == C_MAX) begin
                  ovf_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + C_ONE;
               end
            end
            2'b01:   cnt_r <= cnt_r - C_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign depart   = depart_s;
   assign count    = cnt_r;
   assign overflow = ovf_r;

endmodule

// File: rtl/intersection_traffic_model.sv
// Five-lane intersection model: maps controller lights onto lanes, runs one
// lane_queue per lane, reports queue occupancy as sensors and watches the
// light outputs for illegal simultaneous non-red combinations.
module intersection_traffic_model
   import traffic_model_pkg::*, light_package::*;
#(
   parameter int CNT_W      = 4,
   parameter int STARTUP    = 1,
   parameter int DEPART_GAP = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   intersection_traffic_model_if.slave  bus
);

   colors                        light_s [NUM_LANES];
   logic [NUM_LANES-1:0]         green_s;
   logic [NUM_LANES-1:0]         yellow_s;
   logic [NUM_LANES-1:0]         non_red_s;
   logic [NUM_LANES-1:0]         depart_s;
   logic [NUM_LANES-1:0]         ovf_s;
   logic [NUM_LANES-1:0]         sensor_s;
   logic [CNT_W-1:0]             cnt_s [NUM_LANES];
   logic [NUM_LANES*CNT_W-1:0]   cnt_packed_s;
   logic                         legal_s;
   logic                         conflict_r;
   logic                         conflict_seen_r;

   // Gather the five light inputs into lane order.
   always_comb begin
      light_s[LANE_ES] = bus.e_str_light;
      light_s[LANE_WS] = bus.w_str_light;
      light_s[LANE_EL] = bus.e_left_light;
      light_s[LANE_WL] = bus.w_left_light;
      light_s[LANE_NS] = bus.ns_light;
   end

   // Decode colours: an undefined code stops the lane but counts as lit.
   always_comb begin
      green_s   = {NUM_LANES{1'b0}};
      yellow_s  = {NUM_LANES{1'b0}};
      non_red_s = {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         non_red_s[i] = (light_s[i] != RED);
         case (light_s[i])
            GREEN: begin
               green_s[i]  = 1'b1;
               yellow_s[i] = 1'b0;
            end
            YELLOW: begin
               green_s[i]  = 1'b0;
               yellow_s[i] = 1'b1;
            end
            default: begin
               green_s[i]  = 1'b0;
               yellow_s[i] = 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_queue #(
         .CNT_W      (CNT_W),
         .STARTUP    (STARTUP),
         .DEPART_GAP (DEPART_GAP)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .arrive   (bus.arrive[g]),
         .go       (green_s[g]),
         .amber    (yellow_s[g]),
         .depart   (depart_s[g]),
         .count    (cnt_s[g]),
         .overflow (ovf_s[g])
      );
   end

   // Pack counts and derive sensors from the registered counts only.
   always_comb begin
      cnt_packed_s = {(NUM_LANES*CNT_W){1'b0}};
      sensor_s     = {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         cnt_packed_s[i*CNT_W +: CNT_W] = cnt_s[i];
         sensor_s[i]                    = (cnt_s[i] != {CNT_W{1'b0}});
      end
   end

   // Current light set checked against the legal combinations.
   always_comb begin
      legal_s = light_set_legal(non_red_s);
   end

   // Safety monitor: one-cycle conflict pulse plus sticky history bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_r      <= 1'b0;
         conflict_seen_r <= 1'b0;
      end else begin
         conflict_r <= !legal_s;
         if (!legal_s) begin
            conflict_seen_r <= 1'b1;
         end else begin
            conflict_seen_r <= conflict_seen_r;
         end
      end
   end

   assign bus.e_str_sensor  = sensor_s[LANE_ES];
   assign bus.w_str_sensor  = sensor_s[LANE_WS];
   assign bus.e_left_sensor = sensor_s[LANE_EL];
   assign bus.w_left_sensor = sensor_s[LANE_WL];
   assign bus.ns_sensor     = sensor_s[LANE_NS];
   assign bus.depart        = depart_s;
   assign bus.queue_cnt     = cnt_packed_s;
   assign bus.overflow      = ovf_s;
   assign bus.conflict      = conflict_r;
   assign bus.conflict_seen = conflict_seen_r;

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Table-driven bench for intersection_traffic_model. Each record holds the
// inputs for one clock cycle and the outputs expected during that cycle
// (before the closing edge). Records are queued as they are driven and
// popped for comparison once the DUT outputs have settled.
module tb_intersection_traffic_model;
   import light_package::*;

   localparam int CNT_W = 4;
   localparam colors UNDEF = colors'(2'b11);

   typedef struct packed {
      logic        rst;
      logic [4:0]  arr;
      logic [9:0]  lt;
      logic [4:0]  dep;
      logic [19:0] qc;
      logic [4:0]  ovf;
      logic        conf;
      logic        seen;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   vec_t vecs [$];
   vec_t exp_q [$];
   int   n_vec = 0;
   int   n_err = 0;

   intersection_traffic_model_if #(.CNT_W(CNT_W)) bus ();

   intersection_traffic_model #(
      .CNT_W      (CNT_W),
      .STARTUP    (1),
      .DEPART_GAP (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] lights(colors es, colors ws, colors el, colors wl, colors ns);
      return {ns, wl, el, ws, es};
   endfunction

   function automatic logic [19:0] q(int c0, int c1, int c2, int c3, int c4);
      return {4'(c4), 4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   function automatic vec_t mk(logic rst, logic [4:0] arr, logic [9:0] lt, logic [4:0] dep,
                               logic [19:0] qc, logic [4:0] ovf, logic conf, logic seen);
      vec_t v;
      v.rst = rst; v.arr = arr; v.lt = lt; v.dep = dep;
      v.qc = qc; v.ovf = ovf; v.conf = conf; v.seen = seen;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
      end
   endtask

   task automatic check_out(input int idx);
      vec_t       e;
      logic [4:0] sens_exp;
      logic [4:0] sens_act;
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) sens_exp[i] = (e.qc[i*4 +: 4] != 4'h0);
      sens_act = {bus.ns_sensor, bus.w_left_sensor, bus.e_left_sensor,
                  bus.w_str_sensor, bus.e_str_sensor};
      cmp("depart",        idx, 32'(bus.depart),        32'(e.dep));
      cmp("queue_cnt",     idx, 32'(bus.queue_cnt),     32'(e.qc));
      cmp("sensors",       idx, 32'(sens_act),          32'(sens_exp));
      cmp("overflow",      idx, 32'(bus.overflow),      32'(e.ovf));
      cmp("conflict",      idx, 32'(bus.conflict),      32'(e.conf));
      cmp("conflict_seen", idx, 32'(bus.conflict_seen), 32'(e.seen));
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      reset            = v.rst;
      bus.arrive       = v.arr;
      bus.e_str_light  = colors'(v.lt[1:0]);
      bus.w_str_light  = colors'(v.lt[3:2]);
      bus.e_left_light = colors'(v.lt[5:4]);
      bus.w_left_light = colors'(v.lt[7:6]);
      bus.ns_light     = colors'(v.lt[9:8]);
      exp_q.push_back(v);
      #1;
      check_out(n_vec);
      n_vec++;
   endtask

   initial begin
      logic [9:0] r, esg, esy, wsg, nsg;
      r   = lights(RED,   RED,   RED, RED, RED);
      esg = lights(GREEN, RED,   RED, RED, RED);
      esy = lights(YELLOW,RED,   RED, RED, RED);
      wsg = lights(RED,   GREEN, RED, RED, RED);
      nsg = lights(RED,   RED,   RED, RED, GREEN);

      // three arrivals on ES, then green: departures every DEPART_GAP cycles
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(3,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h01, q(3,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h01, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h01, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      // empty queue on green: next arrival leaves the cycle after it is counted
      vecs.push_back(mk(1'b0, 5'h01, esg, 5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h01, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      // flowing lane keeps departing through yellow
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(3,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h01, q(3,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h00, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h01, q(2,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h01, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      // stopped lane: green then yellow before timer expiry never launches; red freezes
      vecs.push_back(mk(1'b0, 5'h01, r,   5'h00, q(0,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esg, 5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, esy, 5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(1,0,0,0,0), 5'h00, 1'b0, 1'b0));
      // fill NS to 15, then arrive on full queue sets overflow
      for (int k = 0; k < 15; k++)
         vecs.push_back(mk(1'b0, 5'h10, r, 5'h00, q(1,0,0,0,k), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h10, r,   5'h00, q(1,0,0,0,15), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(1,0,0,0,15), 5'h10, 1'b0, 1'b0));
      // reset with arrivals on every lane: arrivals ignored, everything cleared
      vecs.push_back(mk(1'b1, 5'h1F, r,   5'h00, q(1,0,0,0,15), 5'h10, 1'b0, 1'b0));
      for (int k = 0; k < 15; k++)
         vecs.push_back(mk(1'b0, 5'h10, r, 5'h00, q(0,0,0,0,k), 5'h00, 1'b0, 1'b0));
      // full queue: arrive together with depart keeps count, no overflow
      vecs.push_back(mk(1'b0, 5'h00, nsg, 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h10, nsg, 5'h10, q(0,0,0,0,15), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, nsg, 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b0));
      // safety monitor
      vecs.push_back(mk(1'b0, 5'h00, lights(GREEN,RED,RED,RED,YELLOW), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, lights(GREEN,RED,GREEN,RED,RED), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, lights(GREEN,RED,RED,GREEN,RED), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b1, 1'b1));
      // undefined colour: red for flow, lit for the monitor
      vecs.push_back(mk(1'b0, 5'h00, lights(RED,RED,RED,RED,UNDEF), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, lights(RED,RED,RED,RED,UNDEF), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, lights(RED,RED,RED,UNDEF,GREEN), 5'h00, q(0,0,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,15), 5'h00, 1'b1, 1'b1));
      // WS to 7, reset mid-flow with arrivals high
      for (int k = 0; k < 7; k++)
         vecs.push_back(mk(1'b0, 5'h02, r, 5'h00, q(0,k,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h00, wsg, 5'h00, q(0,7,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 5'h1F, wsg, 5'h02, q(0,7,0,0,15), 5'h00, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 5'h02, r,   5'h00, q(0,0,0,0,0),  5'h00, 1'b0, 1'b0));
      // lane restarts from STOPPED with the full startup delay
      vecs.push_back(mk(1'b0, 5'h00, wsg, 5'h00, q(0,1,0,0,0),  5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, wsg, 5'h02, q(0,1,0,0,0),  5'h00, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 5'h00, r,   5'h00, q(0,0,0,0,0),  5'h00, 1'b0, 1'b0));

      reset            = 1'b1;
      bus.arrive       = 5'h00;
      bus.e_str_light  = RED;
      bus.w_str_light  = RED;
      bus.e_left_light = RED;
      bus.w_left_light = RED;
      bus.ns_light     = RED;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/intersection_traffic_model.md
Name: intersection_traffic_model

Overview:
- Behavioural-but-synthesizable model of the five-lane intersection that sits on the other side of traffic_light_controller2.
- Consumes the controller's five light outputs plus per-lane car-arrival pulses, and keeps a car queue per lane.
- Drives the five sensor inputs back to the controller (sensor high = queue non-empty).
- Includes a safety monitor that flags any illegal simultaneous non-red light combination.
- Used in closed-loop benches and FPGA demo.

Parameters:
- CNT_W, 4, queue counter width; max queue = 2**CNT_W-1 (15).
- STARTUP, 1, cycles of green before the first car leaves after red-to-green.
- DEPART_GAP, 2, cycles between successive departures while flowing (must be >=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- arrive  in  5  one-cycle car-arrival pulse per lane.
- e_str_light, w_str_light, e_left_light, w_left_light, ns_light  in  colors  lights from controller.
- e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor  out  1  queue non-empty.
- depart  out  5  strobe: a car leaves this lane this cycle.
- queue_cnt  out  5*CNT_W  packed per-lane counts.
- overflow  out  5  sticky: an arrival was dropped on a full queue.
- conflict  out  1  registered one-cycle flag: illegal light set seen last cycle.
- conflict_seen  out  1  sticky conflict.

Lane index (all 5-bit vectors): 0 e_str, 1 w_str, 2 e_left, 3 w_left, 4 ns.

Behaviour:
- Clock and reset
  - Single clock domain; reset is synchronous and active-high.
  - On reset: all counts 0, sensors 0, depart 0, overflow 0, conflict 0, conflict_seen 0.
  - Every lane goes to STOPPED with timer = STARTUP.
  - Arrivals during the reset cycle are ignored. Reset mid-flow clears everything at that edge.
- Per-lane state machine (states STOPPED, FLOWING; down-counter t):
  - Red: state <= STOPPED, t <= STARTUP, no departure.
  - Green: if t==0 and count>0, then depart=1, t <= DEPART_GAP-1, state <= FLOWING. Otherwise, if t>0, t <= t-1 and state is held.
  - Green with count==0 and t==0: state <= FLOWING, t stays 0 (the next arrival leaves the cycle after it is counted).
  - Yellow: behaves as green only if state==FLOWING. If STOPPED, hold t and never depart (no new launch on yellow).
- depart output
  - Combinational from registered state/count and the current light input.
  - The count update is visible at the next edge.
- Queue counter
  - Next count = count + arrive - depart.
  - Arrive and depart in the same cycle: count unchanged, overflow not set even when full.
  - Arrive while full with no depart: count stays at max and the overflow bit sets (sticky until reset).
  - Depart is never asserted with count==0, so there is no underflow.
- Sensors: sensor = (count != 0), decoded from the registered count (no arrival-to-sensor combinational path).
- Safety monitor
  - Legal non-red sets: subsets of {ES,WS}, {ES,EL}, {WS,WL}, {WL,EL}, {NS}. Green and yellow both count as non-red.
  - Any other combination sets conflict for one cycle at the next edge and sets conflict_seen (sticky).
  - All-red is always legal.
- Undefined colors value on a light input is treated as red for flow and as non-red for the monitor.

Decomposition:
- Package traffic_model_pkg holds:
  - NUM_LANES=5 and lane index constants.
  - lane_state_t enum {STOPPED, FLOWING}.
  - The legal-set mask constants (5'b00011, 5'b00101, 5'b01010, 5'b01100, 5'b10000).
  - The model imports light_package for colors.
- Sub-module lane_queue (parameters CNT_W, STARTUP, DEPART_GAP):
  - Contains one lane's FSM, timer, counter and overflow bit.
  - Instantiated 5x via generate.
  - The top holds the light-to-index mapping, sensor mapping and safety monitor.

Test Plan:
- Reset, then 3 arrive pulses on lane 0 with all lights red -> queue_cnt[0]=3 and e_str_sensor=1 from the edge after the 1st pulse; depart=0.
- Lane 0 count=3, ES turns green at cycle 0 (defaults) -> depart[0] at cycles 1, 3 and 5; count 2, 1, 0; e_str_sensor falls after the cycle-5 edge.
- ES green and FLOWING, count 2, light goes yellow -> departures continue every 2 cycles. From STOPPED, a green-to-yellow change before t reaches 0 gives no departure. Red -> count frozen.
- Lane 4 at 15: an arrive gives count 15 and overflow[4]=1. arrive with depart in the same cycle gives count unchanged and no new overflow.
- Drive ES=green with NS=yellow -> conflict=1 for exactly one cycle, conflict_seen stays 1. ES+EL green -> no conflict. ES+WL green -> conflict.
- Assert reset mid-flow with count 7 and arrive high -> next cycle all counts 0, flags 0, sensors 0, all lanes STOPPED.
